// File: rtl/nt_mon_pkg.sv
// nt_mon_pkg: shared states, default MISR constants and the MISR step function for nt-node monitors
package nt_mon_pkg;
  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_e;
  localparam logic [15:0] DEF_POLY = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'h0001;
  function automatic logic [63:0] misr_step(input logic [63:0] sig, input logic b, input logic [63:0] poly, input int w);
    return (sig << 1) ^ (sig[w-1] ? poly : 64'd0) ^ {63'd0, b};
  endfunction
endpackage

// File: rtl/nt_misr.sv
// nt_misr: single-input MISR with seed load, shared by the nt-node monitors
module nt_misr
  import nt_mon_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             din,
  input  logic [SIG_W-1:0] seed,
  output logic [SIG_W-1:0] sig
);
  logic [SIG_W-1:0] sig_q, sig_d;
  always_comb sig_d = (rst || load) ? seed : en ? SIG_W'(misr_step(64'(sig_q), din, 64'(POLY), SIG_W)) : sig_q;
  always_ff @(posedge clk) sig_q <= sig_d;
  assign sig = sig_q;
endmodule

// File: rtl/nt_node_signature_monitor.sv
// nt_node_signature_monitor: windowed MISR/ones/toggle compaction of I7652 with rare/stuck report handshake
module nt_node_signature_monitor
  import nt_mon_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int CNT_W = 16,
  parameter int WINDOW = 1024,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED = SIG_W'(DEF_SEED),
  parameter int RARE_THRESH = 4
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             I7652,
  input  logic             start,
  input  logic             sample_en,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [SIG_W-1:0] rpt_sig,
  output logic [CNT_W-1:0] rpt_ones,
  output logic [CNT_W-1:0] rpt_toggles,
  output logic             rpt_rare,
  output logic             rpt_stuck,
  output logic             busy
);
  if (WINDOW < 2 || longint'(WINDOW) > (longint'(1) << CNT_W) - 1 || 2 * RARE_THRESH >= WINDOW) begin : g_bad_params
    $error("nt_node_signature_monitor: illegal WINDOW/CNT_W/RARE_THRESH");
  end
  state_e state_q, state_d;
  logic [CNT_W-1:0] ones_q, ones_d, tog_q, tog_d, cnt_q, cnt_d;
  logic [SIG_W-1:0] sig, sig_d;
  logic prev_q, pv_q, take, last, hs, begin_w;
  logic rpt_valid_q, rpt_rare_q, rpt_stuck_q;
  logic [SIG_W-1:0] rpt_sig_q;
  logic [CNT_W-1:0] rpt_ones_q, rpt_tog_q;
  nt_misr #(.SIG_W(SIG_W), .POLY(POLY)) u_misr (
    .clk(I1470_clk), .rst(I1477_rst), .load(begin_w), .en(take), .din(I7652), .seed(SEED), .sig(sig)
  );
  always_comb begin
    take = state_q == RUN && sample_en;
    hs = state_q == REPORT && rpt_ready;
    begin_w = start && (state_q == IDLE || hs);
    ones_d = ones_q + CNT_W'(I7652);
    tog_d = tog_q + CNT_W'(pv_q && I7652 != prev_q);
    cnt_d = cnt_q + CNT_W'(1);
    sig_d = SIG_W'(misr_step(64'(sig), I7652, 64'(POLY), SIG_W));
    last = take && cnt_d == CNT_W'(WINDOW);
    state_d = begin_w ? RUN : last ? REPORT : hs ? IDLE : state_q;
  end
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state_q <= IDLE;
      ones_q <= '0;
      tog_q <= '0;
      cnt_q <= '0;
      prev_q <= 1'b0;
      pv_q <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_sig_q <= '0;
      rpt_ones_q <= '0;
      rpt_tog_q <= '0;
      rpt_rare_q <= 1'b0;
      rpt_stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (begin_w) begin
        ones_q <= '0;
        tog_q <= '0;
        cnt_q <= '0;
        pv_q <= 1'b0;
      end else if (take) begin
        ones_q <= ones_d;
        tog_q <= tog_d;
        cnt_q <= cnt_d;
        prev_q <= I7652;
        pv_q <= 1'b1;
      end
      if (last) begin
        rpt_valid_q <= 1'b1;
        rpt_sig_q <= sig_d;
        rpt_ones_q <= ones_d;
        rpt_tog_q <= tog_d;
        rpt_rare_q <= ones_d <= CNT_W'(RARE_THRESH) || ones_d >= CNT_W'(WINDOW - RARE_THRESH);
        rpt_stuck_q <= tog_d == '0;
      end else if (hs) begin
        rpt_valid_q <= 1'b0;
      end
    end
  end
  assign rpt_valid = rpt_valid_q;
  assign rpt_sig = rpt_sig_q;
  assign rpt_ones = rpt_ones_q;
  assign rpt_toggles = rpt_tog_q;
  assign rpt_rare = rpt_rare_q;
  assign rpt_stuck = rpt_stuck_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_nt_node_signature_monitor.sv
// tb_nt_node_signature_monitor: directed and random checks against a window-queue reference model
module tb_nt_node_signature_monitor;
  localparam int WIN = 8;
  localparam int RT = 1;
  localparam logic [15:0] POLY = 16'hB400;
  localparam logic [15:0] SEED = 16'h0001;
  logic clk = 1'b0;
  logic rst, din, start, sample_en, rpt_ready;
  logic rpt_valid, rpt_rare, rpt_stuck, busy;
  logic [15:0] rpt_sig, rpt_ones, rpt_toggles, saved;
  int checks = 0;
  int errors = 0;
  bit m_run = 0;
  bit m_rpt = 0;
  bit q[$];
  logic [15:0] e_sig;
  int e_ones, e_tog;
  nt_node_signature_monitor #(.WINDOW(WIN), .RARE_THRESH(RT)) dut (
    .I1470_clk(clk), .I1477_rst(rst), .I7652(din), .start(start), .sample_en(sample_en),
    .rpt_ready(rpt_ready), .rpt_valid(rpt_valid), .rpt_sig(rpt_sig), .rpt_ones(rpt_ones),
    .rpt_toggles(rpt_toggles), .rpt_rare(rpt_rare), .rpt_stuck(rpt_stuck), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_run = 0;
      m_rpt = 0;
      q.delete();
    end else if (m_rpt) begin
      if (rpt_ready) begin
        m_rpt = 0;
        if (start) begin
          m_run = 1;
          q.delete();
        end
      end
    end else if (m_run) begin
      if (sample_en) begin
        q.push_back(din);
        if (q.size() == WIN) begin
          e_sig = SEED;
          e_ones = 0;
          e_tog = 0;
          foreach (q[i]) begin
            e_sig = (e_sig << 1) ^ (e_sig[15] ? POLY : 16'h0) ^ 16'(q[i]);
            e_ones += int'(q[i]);
            if (i > 0 && q[i] != q[i-1]) e_tog++;
          end
          m_run = 0;
          m_rpt = 1;
        end
      end
    end else if (start) begin
      m_run = 1;
      q.delete();
    end
  end
  always @(negedge clk) begin
    chk("model_valid", 32'(rpt_valid), 32'(m_rpt));
    chk("model_busy", 32'(busy), 32'(m_run || m_rpt));
    if (m_rpt) begin
      chk("model_sig", 32'(rpt_sig), 32'(e_sig));
      chk("model_ones", 32'(rpt_ones), 32'(e_ones));
      chk("model_toggles", 32'(rpt_toggles), 32'(e_tog));
      chk("model_rare", 32'(rpt_rare), 32'(e_ones <= RT || e_ones >= WIN - RT));
      chk("model_stuck", 32'(rpt_stuck), 32'(e_tog == 0));
    end
  end
  task automatic send(input bit b, input int gap);
    sample_en = 1'b0;
    repeat (gap) @(negedge clk);
    sample_en = 1'b1;
    din = b;
    @(negedge clk);
    sample_en = 1'b0;
    din = 1'($urandom);
  endtask
  task automatic chk_rpt(input logic [15:0] s, input int o, input int t, input bit r, input bit st);
    chk("rpt_valid", 32'(rpt_valid), 32'd1);
    chk("rpt_sig", 32'(rpt_sig), 32'(s));
    chk("rpt_ones", 32'(rpt_ones), 32'(o));
    chk("rpt_toggles", 32'(rpt_toggles), 32'(t));
    chk("rpt_rare", 32'(rpt_rare), 32'(r));
    chk("rpt_stuck", 32'(rpt_stuck), 32'(st));
  endtask
  task automatic handshake(input bit st);
    rpt_ready = 1'b1;
    start = st;
    @(negedge clk);
    rpt_ready = 1'b0;
    start = 1'b0;
    chk("hs_valid", 32'(rpt_valid), 32'd0);
    chk("hs_busy", 32'(busy), 32'(st));
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b1;
    sample_en = 1'b1;
    din = 1'b1;
    rpt_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(rpt_valid), 32'd0);
    chk("reset_sig", 32'(rpt_sig), 32'd0);
    chk("reset_ones", 32'(rpt_ones), 32'd0);
    chk("reset_toggles", 32'(rpt_toggles), 32'd0);
    chk("reset_rare", 32'(rpt_rare), 32'd0);
    chk("reset_stuck", 32'(rpt_stuck), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    sample_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    repeat (WIN) send(1'b0, 0);
    chk_rpt(16'h0100, 0, 0, 1'b1, 1'b1);
    handshake(1'b1);
    repeat (WIN) send(1'b1, 0);
    chk_rpt(16'h01FF, 8, 0, 1'b1, 1'b1);
    handshake(1'b1);
    for (int i = 0; i < WIN; i++) send(1'(i), int'($urandom_range(0, 3)));
    chk("alt_valid", 32'(rpt_valid), 32'd1);
    chk("alt_ones", 32'(rpt_ones), 32'd4);
    chk("alt_toggles", 32'(rpt_toggles), 32'd7);
    chk("alt_rare", 32'(rpt_rare), 32'd0);
    chk("alt_stuck", 32'(rpt_stuck), 32'd0);
    saved = rpt_sig;
    repeat (5) begin
      start = 1'b1;
      sample_en = 1'b1;
      din = 1'($urandom);
      @(negedge clk);
      chk("bp_valid", 32'(rpt_valid), 32'd1);
      chk("bp_sig", 32'(rpt_sig), 32'(saved));
      chk("bp_ones", 32'(rpt_ones), 32'd4);
    end
    sample_en = 1'b0;
    handshake(1'b1);
    repeat (WIN) send(1'b0, 0);
    chk_rpt(16'h0100, 0, 0, 1'b1, 1'b1);
    handshake(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) send(1'b1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(rpt_valid), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (WIN) send(1'b0, 0);
    chk_rpt(16'h0100, 0, 0, 1'b1, 1'b1);
    handshake(1'b0);
    repeat (600) begin
      rst = $urandom_range(0, 149) == 0;
      start = $urandom_range(0, 3) == 0;
      sample_en = $urandom_range(0, 2) != 0;
      din = 1'($urandom);
      rpt_ready = $urandom_range(0, 2) == 0;
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
